alu_arbiter: RTL and testbench

Round-robin scheduler that shares the single combinational ALU between NUM_REQ requesters, such as the issue stage and the address/compare unit. It accepts one operation at a time over a valid/ready handshake and drives the ALU from registered operands. It captures the result, the high product word and the N/Z/C/V flags, and returns them with the requester ID over a second valid/ready handshake.

---
 rtl/alu_arbiter_pkg.sv | 45 ++++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 30 +++
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared ALU ISA definitions and arbiter state encodings.
// ALU_ARB_MUL_STALL_EN: when defined, ALU_MUL takes an extra EXEC2 cycle.
package alu_arbiter_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned OperW = 4;

    // ALU opcodes; any other 4-bit code is undefined and yields all zeros.
    typedef enum logic [OperW-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOT = 4'd5,
        ALU_CMP = 4'd6,
        ALU_MUL = 4'd7
    } alu_op_e;

`ifdef ALU_ARB_MUL_STALL_EN
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StExec  = 2'd1,
        StExec2 = 2'd2,
        StResp  = 2'd3
    } arb_state_e;
`else
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd3
    } arb_state_e;
`endif

    // Captured ALU response payload.
    typedef struct packed {
        logic [DataW-1:0] y;
        logic [DataW-1:0] y_hi;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
    } alu_rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response handshake bundle for alu_arbiter.
// master: requesters/consumer side; slave: arbiter side.
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*4-1:0]  req_oper;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [31:0]           rsp_y;
    logic [31:0]           rsp_y_hi;
    logic                  rsp_n;
    logic                  rsp_z;
    logic                  rsp_c;
    logic                  rsp_v;

    modport master (
        output req_valid, req_a, req_b, req_oper, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_y, rsp_y_hi, rsp_n, rsp_z, rsp_c, rsp_v
    );

    modport slave (
        input  req_valid, req_a, req_b, req_oper, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_y, rsp_y_hi, rsp_n, rsp_z, rsp_c, rsp_v
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request after last_grant, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IdW-1:0]     last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IdW-1:0]     grant_idx_o
);

    // Scan from last_grant+1 around to last_grant; first hit wins.
    always_comb begin
        logic           found;
        logic [IdW-1:0] cand;
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IdW'((32'(last_grant_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one combinational ALU between NUM_REQ requesters.
// ALU_ARB_MUL_STALL_EN: when defined, ALU_MUL spends EXEC plus EXEC2 (2-cycle path).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ID_W    = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_arbiter_if.slave        arb_if,
    output logic [DataW-1:0]    alu_a_o,
    output logic [DataW-1:0]    alu_b_o,
    output logic [OperW-1:0]    alu_oper_o,
    input  logic [DataW-1:0]    alu_y_i,
    input  logic [DataW-1:0]    alu_y_hi_i,
    input  logic                alu_n_i,
    input  logic                alu_z_i,
    input  logic                alu_c_i,
    input  logic                alu_v_i
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [DataW-1:0] alu_a_q, alu_a_d;
    logic [DataW-1:0] alu_b_q, alu_b_d;
    logic [OperW-1:0] alu_oper_q, alu_oper_d;
    alu_rsp_t         rsp_q, rsp_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic [DataW-1:0]   sel_a, sel_b;
    logic [OperW-1:0]   sel_oper;
    logic               capture;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i        (arb_if.req_valid),
        .last_grant_i (last_grant_q),
        .grant_o      (grant),
        .grant_idx_o  (grant_idx)
    );

    // One-hot mux of the granted requester's operands.
    always_comb begin
        sel_a    = '0;
        sel_b    = '0;
        sel_oper = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a    |= arb_if.req_a[32*i +: 32];
                sel_b    |= arb_if.req_b[32*i +: 32];
                sel_oper |= arb_if.req_oper[4*i +: 4];
            end
        end
    end

    // Next-state and datapath load decisions.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_oper_d   = alu_oper_q;
        rsp_d        = rsp_q;
        rsp_id_d     = rsp_id_q;
        capture      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (|grant) begin
                    last_grant_d = grant_idx;
                    id_d         = grant_idx;
                    alu_a_d      = sel_a;
                    alu_b_d      = sel_b;
                    alu_oper_d   = sel_oper;
                    state_d      = StExec;
                end
            end
            StExec: begin
`ifdef ALU_ARB_MUL_STALL_EN
                if (alu_oper_q == ALU_MUL) begin
                    state_d = StExec2;
                end else begin
                    capture = 1'b1;
                    state_d = StResp;
                end
`else
                capture = 1'b1;
                state_d = StResp;
`endif
            end
`ifdef ALU_ARB_MUL_STALL_EN
            StExec2: begin
                capture = 1'b1;
                state_d = StResp;
            end
`endif
            StResp: begin
                if (arb_if.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            rsp_d.y    = alu_y_i;
            rsp_d.y_hi = alu_y_hi_i;
            rsp_d.n    = alu_n_i;
            rsp_d.z    = alu_z_i;
            rsp_d.c    = alu_c_i;
            rsp_d.v    = alu_v_i;
            rsp_id_d   = id_q;
        end
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_oper_q   <= '0;
            rsp_q        <= '0;
            rsp_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_oper_q   <= alu_oper_d;
            rsp_q        <= rsp_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // Grant is only visible in IDLE and is held off while reset is asserted.
    assign arb_if.req_ready = (state_q == StIdle && !rst) ? grant : '0;

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_oper_o = alu_oper_q;

    assign arb_if.rsp_valid = (state_q == StResp);
    assign arb_if.rsp_id    = rsp_id_q;
    assign arb_if.rsp_y     = rsp_q.y;
    assign arb_if.rsp_y_hi  = rsp_q.y_hi;
    assign arb_if.rsp_n     = rsp_q.n;
    assign arb_if.rsp_z     = rsp_q.z;
    assign arb_if.rsp_c     = rsp_q.c;
    assign arb_if.rsp_v     = rsp_q.v;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU alongside the DUT.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

`ifdef ALU_ARB_MUL_STALL_EN
    localparam int MulLat = 3;
`else
    localparam int MulLat = 2;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] alu_a, alu_b, alu_y, alu_y_hi;
    logic [3:0]  alu_oper;
    logic        alu_n, alu_z, alu_c, alu_v;

    int n_checks;
    int n_errs;

    alu_arbiter_if #(.NUM_REQ(2), .ID_W(1)) bus_if ();

    alu_arbiter #(
        .NUM_REQ (2),
        .ID_W    (1)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .arb_if     (bus_if),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_oper_o (alu_oper),
        .alu_y_i    (alu_y),
        .alu_y_hi_i (alu_y_hi),
        .alu_n_i    (alu_n),
        .alu_z_i    (alu_z),
        .alu_c_i    (alu_c),
        .alu_v_i    (alu_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: C on SUB/CMP is borrow (a < b); MUL sets C and V when y_hi != 0.
    always_comb begin
        logic [32:0] sum;
        logic [31:0] diff;
        logic [63:0] prod;
        alu_y    = '0;
        alu_y_hi = '0;
        alu_n    = 1'b0;
        alu_z    = 1'b0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        sum      = 33'(alu_a) + 33'(alu_b);
        diff     = alu_a - alu_b;
        prod     = 64'(alu_a) * 64'(alu_b);
        case (alu_oper)
            ALU_ADD: begin
                alu_y = sum[31:0];
                alu_c = sum[32];
                alu_v = (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]);
                alu_n = alu_y[31];
                alu_z = (alu_y == 0);
            end
            ALU_SUB, ALU_CMP: begin
                alu_y = (alu_oper == ALU_CMP) ? 32'd0 : diff;
                alu_c = (alu_a < alu_b);
                alu_v = (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31]);
                alu_n = diff[31];
                alu_z = (diff == 0);
            end
            ALU_AND, ALU_OR, ALU_XOR, ALU_NOT: begin
                case (alu_oper)
                    ALU_AND: alu_y = alu_a & alu_b;
                    ALU_OR:  alu_y = alu_a | alu_b;
                    ALU_XOR: alu_y = alu_a ^ alu_b;
                    default: alu_y = ~alu_a;
                endcase
                alu_n = alu_y[31];
                alu_z = (alu_y == 0);
            end
            ALU_MUL: begin
                alu_y    = prod[31:0];
                alu_y_hi = prod[63:32];
                alu_n    = prod[63];
                alu_z    = (prod == 0);
                alu_c    = (prod[63:32] != 0);
                alu_v    = (prod[63:32] != 0);
            end
            default: ;
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_slice(input int idx, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op);
        bus_if.req_a[idx*32 +: 32]  = a;
        bus_if.req_b[idx*32 +: 32]  = b;
        bus_if.req_oper[idx*4 +: 4] = op;
    endtask

    function automatic logic [3:0] rsp_flags();
        return {bus_if.rsp_n, bus_if.rsp_z, bus_if.rsp_c, bus_if.rsp_v};
    endfunction

    // Issue one op from requester idx (called at posedge+1 in IDLE) and check its response.
    task automatic run_op(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] exp_y, input logic [31:0] exp_hi,
                          input logic [3:0] exp_nzcv, input int exp_lat);
        logic [1:0] onehot;
        int lat;
        onehot = 2'b01 << idx;
        set_slice(idx, a, b, op);
        bus_if.req_valid = onehot;
        #1;
        check_eq({tag, ".grant"}, 64'(bus_if.req_ready), 64'(onehot));
        @(posedge clk); #1;
        bus_if.req_valid = '0;
        set_slice(idx, 32'hDEAD_BEEF, 32'h1234_5678, 4'(ALU_OR));
        lat = 1;
        while (!bus_if.rsp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, ".y"}, 64'(bus_if.rsp_y), 64'(exp_y));
        check_eq({tag, ".y_hi"}, 64'(bus_if.rsp_y_hi), 64'(exp_hi));
        check_eq({tag, ".nzcv"}, 64'(rsp_flags()), 64'(exp_nzcv));
        check_eq({tag, ".id"}, 64'(bus_if.rsp_id), 64'(idx));
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
        check_eq({tag, ".released"}, 64'(bus_if.rsp_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks         = 0;
        n_errs           = 0;
        rst              = 1'b1;
        bus_if.req_valid = '0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        bus_if.req_oper  = '0;
        bus_if.rsp_ready = 1'b0;

        // Reset state, with requests pending while reset is held.
        repeat (3) @(posedge clk);
        #1;
        bus_if.req_valid = 2'b11;
        #1;
        check_eq("rst.req_ready", 64'(bus_if.req_ready), 64'd0);
        check_eq("rst.rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
        check_eq("rst.alu_a", 64'(alu_a), 64'd0);
        check_eq("rst.alu_oper", 64'(alu_oper), 64'd0);
        check_eq("rst.rsp_y", 64'(bus_if.rsp_y), 64'd0);
        bus_if.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;

        // Basic ADD from requester 0: grant in cycle 0, response in cycle 2.
        run_op("add5_7", 0, 32'd5, 32'd7, 4'(ALU_ADD), 32'd12, 32'd0, 4'b0000, 2);

        // Contention after reset: grants alternate 0,1,0,1 with matching IDs.
        do_reset();
        set_slice(0, 32'd10, 32'd1, 4'(ALU_SUB));
        set_slice(1, 32'd3, 32'd4, 4'(ALU_ADD));
        bus_if.req_valid = 2'b11;
        bus_if.rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("rr%0d.grant", k), 64'(bus_if.req_ready), 64'(2'b01 << (k % 2)));
            @(posedge clk); #1;
            @(posedge clk); #1;
            check_eq($sformatf("rr%0d.valid", k), 64'(bus_if.rsp_valid), 64'd1);
            check_eq($sformatf("rr%0d.id", k), 64'(bus_if.rsp_id), 64'(k % 2));
            check_eq($sformatf("rr%0d.y", k), 64'(bus_if.rsp_y), (k % 2 == 1) ? 64'd7 : 64'd9);
            if (k == 3) bus_if.req_valid = '0;
            @(posedge clk); #1;
        end
        bus_if.rsp_ready = 1'b0;

        // Backpressure: SUB 0-0 held for 10 cycles while requester 1 waits.
        set_slice(0, 32'd0, 32'd0, 4'(ALU_SUB));
        set_slice(1, 32'h0001_0000, 32'h0001_0000, 4'(ALU_MUL));
        bus_if.req_valid = 2'b11;
        #1;
        check_eq("bp.grant", 64'(bus_if.req_ready), 64'(2'b01));
        @(posedge clk); #1;
        bus_if.req_valid = 2'b10;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            check_eq($sformatf("bp%0d.valid", k), 64'(bus_if.rsp_valid), 64'd1);
            check_eq($sformatf("bp%0d.z", k), 64'(bus_if.rsp_z), 64'd1);
            check_eq($sformatf("bp%0d.y", k), 64'(bus_if.rsp_y), 64'd0);
            check_eq($sformatf("bp%0d.req_ready", k), 64'(bus_if.req_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus_if.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.rsp_ready = 1'b0;
        #1;
        check_eq("bp.release_valid", 64'(bus_if.rsp_valid), 64'd0);
        check_eq("bp.release_grant", 64'(bus_if.req_ready), 64'(2'b10));

        // Remaining opcodes and flag corners.
        run_op("mul", 1, 32'h0001_0000, 32'h0001_0000, 4'(ALU_MUL),
               32'd0, 32'd1, 4'b0011, MulLat);
        run_op("cmp3_3", 0, 32'd3, 32'd3, 4'(ALU_CMP), 32'd0, 32'd0, 4'b0100, 2);
        run_op("add_ovf", 0, 32'h7FFF_FFFF, 32'd1, 4'(ALU_ADD),
               32'h8000_0000, 32'd0, 4'b1001, 2);
        run_op("add_carry", 1, 32'hFFFF_FFFF, 32'd1, 4'(ALU_ADD), 32'd0, 32'd0, 4'b0110, 2);
        run_op("not", 0, 32'hF0F0_0000, 32'd0, 4'(ALU_NOT), 32'h0F0F_FFFF, 32'd0, 4'b0000, 2);
        run_op("and", 1, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'(ALU_AND),
               32'h0F00_0F00, 32'd0, 4'b0000, 2);
        run_op("undef", 1, 32'd1, 32'd2, 4'hF, 32'd0, 32'd0, 4'b0000, 2);
        run_op("xor", 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'(ALU_XOR),
               32'hF0F0_F0F0, 32'd0, 4'b1000, 2);

        // Mid-operation reset: requester 0 accepted, reset during EXEC.
        set_slice(0, 32'd1, 32'd1, 4'(ALU_ADD));
        bus_if.req_valid = 2'b01;
        #1;
        check_eq("mid.grant", 64'(bus_if.req_ready), 64'(2'b01));
        @(posedge clk); #1;
        bus_if.req_valid = 2'b11;
        rst = 1'b1;
        #1;
        check_eq("mid.rst_valid", 64'(bus_if.rsp_valid), 64'd0);
        check_eq("mid.rst_ready", 64'(bus_if.req_ready), 64'd0);
        check_eq("mid.rst_alu_a", 64'(alu_a), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_eq("mid.first_grant", 64'(bus_if.req_ready), 64'(2'b01));
        bus_if.req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check_eq($sformatf("mid%0d.no_rsp", k), 64'(bus_if.rsp_valid), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
